// File: rtl/upstream_order_accum.sv
// rtl/upstream_order_accum.sv - per-client order accumulator issuing threshold trades
module upstream_order_accum #(
  parameter int NUM_CLIENTS = 32,
  parameter int ID_W        = 5,
  parameter int AMT_W       = 16,
  parameter int ACC_W       = 32,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             new_order,
  input  logic [ID_W-1:0]  client_id,
  input  logic [AMT_W-1:0] amount,
  input  logic             new_max,
  input  logic [ACC_W-1:0] max_value,
  output logic             order_ready,
  output logic             trade_valid,
  output logic [ID_W-1:0]  trade_client,
  output logic [ACC_W-1:0] trade_amount,
  input  logic             trade_ready,
  output logic [CNT_W-1:0] accumulated_orders,
  output logic [ACC_W-1:0] max_to_trade,
  output logic             thenewmax,
  output logic             err_client
);

  logic [ACC_W-1:0] acc_q [NUM_CLIENTS];
  logic [ACC_W-1:0] thr_q [NUM_CLIENTS];

  logic             trade_valid_q, trade_valid_d;
  logic [ID_W-1:0]  trade_client_q, trade_client_d;
  logic [ACC_W-1:0] trade_amount_q, trade_amount_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] max_q, max_d;
  logic             thenewmax_q, thenewmax_d;
  logic             err_q, err_d;

  logic             id_ok, accept, hit, load;
  logic [ACC_W-1:0] cur_acc, cur_thr, sum;
  logic [ACC_W:0]   sum_ext;

  always_comb begin
    id_ok       = 32'(client_id) < NUM_CLIENTS;
    cur_acc     = id_ok ? acc_q[client_id] : '0;
    cur_thr     = id_ok ? thr_q[client_id] : '0;
    // One extra bit catches the carry so the sum clamps instead of wrapping
    sum_ext     = {1'b0, cur_acc} + (ACC_W+1)'(amount);
    sum         = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
    hit         = (cur_thr != '0) && (sum >= cur_thr);
    order_ready = (!trade_valid_q || trade_ready) && !new_max;
    accept      = new_order && order_ready;
    load        = accept && id_ok && hit;

    trade_valid_d  = trade_valid_q;
    trade_client_d = trade_client_q;
    trade_amount_d = trade_amount_q;
    max_d          = max_q;
    if (load) begin
      trade_valid_d  = 1'b1;
      trade_client_d = client_id;
      trade_amount_d = sum;
      if (sum > max_q) max_d = sum;
    end else if (trade_valid_q && trade_ready) begin
      trade_valid_d = 1'b0;
    end

    cnt_d = cnt_q;
    if (accept && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);

    thenewmax_d = new_max && id_ok;
    err_d       = (new_max || accept) && !id_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        acc_q[i] <= '0;
        thr_q[i] <= '0;
      end
      trade_valid_q  <= 1'b0;
      trade_client_q <= '0;
      trade_amount_q <= '0;
      cnt_q          <= '0;
      max_q          <= '0;
      thenewmax_q    <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      // accept already excludes new_max, so the two array writes never collide
      if (accept && id_ok) acc_q[client_id] <= hit ? '0 : sum;
      if (new_max && id_ok) thr_q[client_id] <= max_value;
      trade_valid_q  <= trade_valid_d;
      trade_client_q <= trade_client_d;
      trade_amount_q <= trade_amount_d;
      cnt_q          <= cnt_d;
      max_q          <= max_d;
      thenewmax_q    <= thenewmax_d;
      err_q          <= err_d;
    end
  end

  assign trade_valid        = trade_valid_q;
  assign trade_client       = trade_client_q;
  assign trade_amount       = trade_amount_q;
  assign accumulated_orders = cnt_q;
  assign max_to_trade       = max_q;
  assign thenewmax          = thenewmax_q;
  assign err_client         = err_q;

endmodule

// File: tb/tb_upstream_order_accum.sv
// tb/tb_upstream_order_accum.sv - directed self-checking bench for upstream_order_accum
module tb_upstream_order_accum;
  localparam int NC = 24, IW = 5, AW = 16, ACW = 20, CW = 5;

  logic clk = 1'b0, rst = 1'b1;
  logic new_order = 0, new_max = 0, trade_ready = 0;
  logic [IW-1:0] client_id = '0;
  logic [AW-1:0] amount = '0;
  logic [ACW-1:0] max_value = '0;
  logic order_ready, trade_valid, thenewmax, err_client;
  logic [IW-1:0] trade_client;
  logic [ACW-1:0] trade_amount, max_to_trade;
  logic [CW-1:0] accumulated_orders;
  int n_cmp = 0, n_bad = 0;

  upstream_order_accum #(.NUM_CLIENTS(NC), .ID_W(IW), .AMT_W(AW), .ACC_W(ACW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .new_order(new_order), .client_id(client_id), .amount(amount),
    .new_max(new_max), .max_value(max_value), .order_ready(order_ready),
    .trade_valid(trade_valid), .trade_client(trade_client), .trade_amount(trade_amount),
    .trade_ready(trade_ready), .accumulated_orders(accumulated_orders),
    .max_to_trade(max_to_trade), .thenewmax(thenewmax), .err_client(err_client));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic order(input int id, input int amt);
    new_order = 1'b1; client_id = IW'(id); amount = AW'(amt);
  endtask

  task automatic test_reset();
    rst = 1'b1; #2;
    n_cmp++; if (trade_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tv got=%b exp=0", trade_valid); end
    n_cmp++; if (accumulated_orders !== 5'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d exp=0", accumulated_orders); end
    n_cmp++; if (max_to_trade !== 20'd0) begin n_bad++; $display("FAIL reset_max got=%0d exp=0", max_to_trade); end
    n_cmp++; if ({thenewmax, err_client} !== 2'b00) begin n_bad++; $display("FAIL reset_pulses got=%b exp=00", {thenewmax, err_client}); end
    n_cmp++; if (order_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", order_ready); end
    cyc(); cyc(); rst = 1'b0;
  endtask

  task automatic test_basic_trade();
    trade_ready = 1'b1; new_max = 1'b1; client_id = 5'd3; max_value = 20'd100;
    cyc();
    n_cmp++; if (thenewmax !== 1'b1) begin n_bad++; $display("FAIL basic_newmax got=%b exp=1", thenewmax); end
    new_max = 1'b0; order(3, 40); #1;
    n_cmp++; if (order_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready got=%b exp=1", order_ready); end
    cyc();
    n_cmp++; if (thenewmax !== 1'b0) begin n_bad++; $display("FAIL basic_newmax_drop got=%b exp=0", thenewmax); end
    n_cmp++; if (trade_valid !== 1'b0) begin n_bad++; $display("FAIL basic_no_trade got=%b exp=0", trade_valid); end
    order(3, 40); cyc();
    order(3, 30); cyc();
    n_cmp++; if ({trade_valid, trade_client, trade_amount} !== {1'b1, 5'd3, 20'd110}) begin n_bad++;
      $display("FAIL basic_trade got=%b/%0d/%0d exp=1/3/110", trade_valid, trade_client, trade_amount); end
    n_cmp++; if (max_to_trade !== 20'd110) begin n_bad++; $display("FAIL basic_max got=%0d exp=110", max_to_trade); end
    n_cmp++; if (accumulated_orders !== 5'd3) begin n_bad++; $display("FAIL basic_cnt got=%0d exp=3", accumulated_orders); end
    new_order = 1'b0; cyc();
    n_cmp++; if (trade_valid !== 1'b0) begin n_bad++; $display("FAIL basic_handshake got=%b exp=0", trade_valid); end
    order(3, 99); cyc();
    n_cmp++; if (trade_valid !== 1'b0) begin n_bad++; $display("FAIL acc_cleared_99 got=%b exp=0", trade_valid); end
    order(3, 1); cyc();
    n_cmp++; if ({trade_valid, trade_amount} !== {1'b1, 20'd100}) begin n_bad++;
      $display("FAIL acc_cleared_trade got=%b/%0d exp=1/100", trade_valid, trade_amount); end
    n_cmp++; if (max_to_trade !== 20'd110) begin n_bad++; $display("FAIL max_keeps got=%0d exp=110", max_to_trade); end
    new_order = 1'b0; cyc();
  endtask

  task automatic test_backpressure();
    trade_ready = 1'b0; order(3, 100); cyc();
    n_cmp++; if ({trade_valid, trade_amount, accumulated_orders} !== {1'b1, 20'd100, 5'd6}) begin n_bad++;
      $display("FAIL bp_load got=%b/%0d/%0d exp=1/100/6", trade_valid, trade_amount, accumulated_orders); end
    order(5, 7); #1;
    n_cmp++; if (order_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_low got=%b exp=0", order_ready); end
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_cmp++; if ({trade_valid, trade_client, trade_amount, accumulated_orders} !== {1'b1, 5'd3, 20'd100, 5'd6}) begin n_bad++;
        $display("FAIL bp_hold%0d got=%b/%0d/%0d/%0d exp=1/3/100/6", i, trade_valid, trade_client, trade_amount, accumulated_orders); end
    end
    trade_ready = 1'b1; #1;
    n_cmp++; if (order_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_high got=%b exp=1", order_ready); end
    cyc();
    n_cmp++; if ({trade_valid, accumulated_orders} !== {1'b0, 5'd7}) begin n_bad++;
      $display("FAIL bp_release got=%b/%0d exp=0/7", trade_valid, accumulated_orders); end
    new_order = 1'b0;
  endtask

  task automatic test_back_to_back();
    order(3, 100); cyc();
    n_cmp++; if ({trade_valid, trade_amount} !== {1'b1, 20'd100}) begin n_bad++;
      $display("FAIL b2b_first got=%b/%0d exp=1/100", trade_valid, trade_amount); end
    order(3, 150); cyc();
    n_cmp++; if ({trade_valid, trade_amount, max_to_trade, accumulated_orders} !== {1'b1, 20'd150, 20'd150, 5'd9}) begin n_bad++;
      $display("FAIL b2b_second got=%b/%0d/%0d/%0d exp=1/150/150/9", trade_valid, trade_amount, max_to_trade, accumulated_orders); end
    new_order = 1'b0; cyc();
    n_cmp++; if (trade_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drop got=%b exp=0", trade_valid); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 17; i++) begin
      order(7, 16'hFFFF); cyc();
      n_cmp++; if (trade_valid !== 1'b0) begin n_bad++; $display("FAIL sat_no_trade%0d got=%b exp=0", i, trade_valid); end
    end
    n_cmp++; if (accumulated_orders !== 5'd26) begin n_bad++; $display("FAIL sat_cnt got=%0d exp=26", accumulated_orders); end
    new_order = 1'b0; new_max = 1'b1; client_id = 5'd7; max_value = 20'hFFFFF; cyc();
    new_max = 1'b0; order(7, 0); cyc();
    n_cmp++; if ({trade_valid, trade_client, trade_amount, max_to_trade} !== {1'b1, 5'd7, 20'hFFFFF, 20'hFFFFF}) begin n_bad++;
      $display("FAIL sat_value got=%b/%0d/%h/%h exp=1/7/fffff/fffff", trade_valid, trade_client, trade_amount, max_to_trade); end
    new_order = 1'b0; cyc();
  endtask

  task automatic test_collision();
    order(2, 10); new_max = 1'b1; max_value = 20'd10; #1;
    n_cmp++; if (order_ready !== 1'b0) begin n_bad++; $display("FAIL col_ready got=%b exp=0", order_ready); end
    cyc();
    n_cmp++; if ({thenewmax, trade_valid, accumulated_orders} !== {1'b1, 1'b0, 5'd27}) begin n_bad++;
      $display("FAIL col_update got=%b/%b/%0d exp=1/0/27", thenewmax, trade_valid, accumulated_orders); end
    new_max = 1'b0; cyc();
    n_cmp++; if ({trade_valid, trade_client, trade_amount, accumulated_orders} !== {1'b1, 5'd2, 20'd10, 5'd28}) begin n_bad++;
      $display("FAIL col_accept got=%b/%0d/%0d/%0d exp=1/2/10/28", trade_valid, trade_client, trade_amount, accumulated_orders); end
    new_order = 1'b0; cyc();
  endtask

  task automatic test_bad_id();
    order(NC, 5); cyc();
    n_cmp++; if ({err_client, trade_valid, accumulated_orders} !== {1'b1, 1'b0, 5'd29}) begin n_bad++;
      $display("FAIL bad_order got=%b/%b/%0d exp=1/0/29", err_client, trade_valid, accumulated_orders); end
    new_order = 1'b0; cyc();
    n_cmp++; if (err_client !== 1'b0) begin n_bad++; $display("FAIL bad_pulse_end got=%b exp=0", err_client); end
    new_max = 1'b1; client_id = 5'd30; max_value = 20'd1; cyc();
    n_cmp++; if ({err_client, thenewmax} !== 2'b10) begin n_bad++; $display("FAIL bad_newmax got=%b exp=10", {err_client, thenewmax}); end
    new_max = 1'b0;
    for (int i = 0; i < 5; i++) begin order(NC, 1); cyc(); end
    n_cmp++; if (accumulated_orders !== 5'd31) begin n_bad++; $display("FAIL cnt_saturate got=%0d exp=31", accumulated_orders); end
    new_order = 1'b0; cyc();
  endtask

  task automatic test_reset_mid();
    trade_ready = 1'b0; order(2, 10); cyc();
    n_cmp++; if (trade_valid !== 1'b1) begin n_bad++; $display("FAIL rm_pending got=%b exp=1", trade_valid); end
    new_order = 1'b0; #2 rst = 1'b1; #1;
    n_cmp++; if ({trade_valid, trade_amount, accumulated_orders, max_to_trade} !== '0) begin n_bad++;
      $display("FAIL rm_clear got=%b/%0d/%0d/%0d exp=0/0/0/0", trade_valid, trade_amount, accumulated_orders, max_to_trade); end
    cyc(); rst = 1'b0; trade_ready = 1'b1;
    order(2, 10); cyc();
    n_cmp++; if ({trade_valid, accumulated_orders} !== {1'b0, 5'd1}) begin n_bad++;
      $display("FAIL rm_thr_cleared got=%b/%0d exp=0/1", trade_valid, accumulated_orders); end
    new_order = 1'b0; cyc();
  endtask

  initial begin
    test_reset();
    test_basic_trade();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_collision();
    test_bad_id();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/upstream_order_accum.md
UPSTREAM_ORDER_ACCUM -- requirements
Module: upstream_order_accum

Interface
REQ-001 Parameter NUM_CLIENTS, default 32: number of client slots, 2..32.
REQ-002 Parameter ID_W, default 5: client_id width, 2^ID_W >= NUM_CLIENTS.
REQ-003 Parameter AMT_W, default 16: order amount width.
REQ-004 Parameter ACC_W, default 32: per-client accumulator, threshold and trade width, ACC_W >= AMT_W.
REQ-005 Parameter CNT_W, default 16: accepted-order counter width.
REQ-006 Ports: clk in 1, the single clock; rst in 1, asynchronous active-high reset.
REQ-007 Ports: new_order in 1, order request; client_id in ID_W, target client; amount in AMT_W, order amount.
REQ-008 Ports: new_max in 1, threshold-update strobe; max_value in ACC_W, new threshold for client_id.
REQ-009 Ports: order_ready out 1, order accepted this cycle if new_order is high.
REQ-010 Ports: trade_valid out 1, trade_client out ID_W, trade_amount out ACC_W, trade output; trade_ready in 1.
REQ-011 Ports: accumulated_orders out CNT_W, accepted-order count; max_to_trade out ACC_W, largest trade emitted; thenewmax out 1, update pulse; err_client out 1, bad-id pulse.

Function
REQ-012 The block SHALL hold per client acc[i] (ACC_W) and thr[i] (ACC_W); thr[i]=0 disables trading for client i.
REQ-013 order_ready SHALL equal (!trade_valid || trade_ready) && !new_max, combinationally.
REQ-014 An order is accepted on a rising edge with new_order && order_ready.
REQ-015 Accepted order with client_id < NUM_CLIENTS: sum = acc[id] + amount, saturated at 2^ACC_W-1.
REQ-016 If thr[id] != 0 and sum >= thr[id], a trade SHALL be issued at that edge: trade_valid=1, trade_client=id, trade_amount=sum, and acc[id] cleared to 0. Otherwise acc[id] = sum.
REQ-017 Trade outputs are registered: visible the cycle after acceptance. They SHALL hold stable until trade_valid && trade_ready at an edge, then drop unless a new trade loads in the same edge.
REQ-018 A trade loading on the same edge as the previous trade's handshake SHALL produce back-to-back trades with no bubble.
REQ-019 On each trade load, max_to_trade SHALL take trade_amount if greater than its current value.
REQ-020 accumulated_orders SHALL increment on every accepted order (including bad id) and saturate at 2^CNT_W-1.
REQ-021 Accepted order with client_id >= NUM_CLIENTS: no accumulator change, no trade, err_client=1 for one cycle.
REQ-022 new_max with client_id < NUM_CLIENTS: thr[id]=max_value at the edge, thenewmax=1 for the next cycle only. acc[id] is unchanged and is not re-checked until the next order.
REQ-023 new_max with client_id >= NUM_CLIENTS: ignored, err_client pulses, thenewmax stays 0.
REQ-024 new_max and new_order high together: the threshold update wins; the order is not accepted (order_ready=0) and must be held by the source.
REQ-025 Accumulator saturation SHALL NOT wrap; a saturated acc with thr[id]=0 stays at 2^ACC_W-1.

Reset
REQ-026 rst SHALL asynchronously clear all acc[i], thr[i], trade_valid, trade_client, trade_amount, accumulated_orders, max_to_trade, thenewmax and err_client to 0.
REQ-027 A pending unacknowledged trade SHALL be discarded by rst. The first edge after rst deasserts SHALL behave as idle-state operation.

Verification
REQ-028 new_max id=3 max_value=100, then orders id=3 amounts 40,40,30 with trade_ready=1 -> thenewmax pulse; third order yields trade_valid, client 3, amount 110; acc[3]=0; max_to_trade=110; accumulated_orders=3.
REQ-029 trade pending with trade_ready=0, new_order=1 -> order_ready=0 and the trade held stable for 5 cycles; raising trade_ready completes the handshake and the order is accepted that edge.
REQ-030 thr[7]=0, orders id=7 amount 0xFFFF repeated past 2^ACC_W -> acc[7] saturates at 2^ACC_W-1, no trade issued.
REQ-031 new_order and new_max together for id=2 -> threshold updated, order not accepted, accumulated_orders unchanged; order accepted the next cycle.
REQ-032 order with client_id=NUM_CLIENTS -> err_client pulse; count increments; no trade.
REQ-033 rst asserted mid-cycle with a trade pending -> trade_valid drops immediately; all counters read 0.
